// File: rtl/axi_ic_pkg.sv
// Shared interconnect types and helpers.
// Entry layout is {id, len, split}, MSB to LSB.
package axi_ic_pkg;

  localparam int LEN_W_DEF = 8;

  function automatic int clog2_min1(input int n);
    int r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int entry_w(input int id_w, input int len_w);
    return id_w + len_w + 1;
  endfunction

  typedef struct packed {
    logic [1:0]           id;
    logic [LEN_W_DEF-1:0] len;
    logic                 split;
  } wdo_entry_t;

endpackage

// File: rtl/axi_ic_sync_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO.
// Pointers carry a wrap bit above the index.
module axi_ic_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int PW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [PW-1:0]    count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;

  // Pointer advance on push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (push) r_wptr <= r_wptr + 1'b1;
      if (pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage write; contents need no reset.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wptr[AW-1:0]] <= wdata;
  end

  assign rdata = r_mem[r_rptr[AW-1:0]];
  assign empty = (r_wptr == r_rptr);
  assign full  = (r_wptr[AW] != r_rptr[AW]) &&
                 (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign count = r_wptr - r_rptr;

endmodule

// File: rtl/wdata_order_queue.sv
// W-data ordering queue: one entry per AW grant, head retires on last beat.
// Optional WLAST cross-check under WDATA_ORDER_WLAST_CHECK_EN.
module wdata_order_queue
  import axi_ic_pkg::*;
#(
  parameter int MASTERS_NUM = 4,
  parameter int ID_SIZE = clog2_min1(MASTERS_NUM),
  parameter int DEPTH = 4,
  parameter int LEN_W = LEN_W_DEF,
  localparam int CW = $clog2(DEPTH) + 1,
  localparam int EW = entry_w(ID_SIZE, LEN_W)
) (
  input  logic               ACLK,
  input  logic               ARESET,
  input  logic               AW_Access_Grant,
  input  logic [ID_SIZE-1:0] AW_Master_ID,
  input  logic [LEN_W-1:0]   AW_Len,
  input  logic               AW_Is_Split,
  input  logic               W_Beat_Accept,
  input  logic               W_Last,
  output logic               Queue_Full,
  output logic               Queue_Empty,
  output logic [CW-1:0]      Queue_Count,
  output logic               Master_Valid,
  output logic [ID_SIZE-1:0] Write_Data_Master,
  output logic               Is_Master_Part_Of_Split,
  output logic [LEN_W:0]     Beats_Remaining,
  output logic               Write_Data_HandShake_En_Pulse,
  output logic               Overflow_Err,
  output logic               Len_Error
);

  logic [EW-1:0]      w_head;
  logic [ID_SIZE-1:0] w_head_id;
  logic [LEN_W-1:0]   w_head_len;
  logic               w_head_split;
  logic               w_valid;
  logic               w_last_beat;
  logic               w_beat;
  logic               w_pop;
  logic               w_push_ok;
  logic [LEN_W-1:0]   r_beat_cnt;
  logic               r_head_seen;
  logic               r_ovf;

  axi_ic_sync_fifo #(.DEPTH(DEPTH), .WIDTH(EW)) u_fifo (
    .clk   (ACLK),
    .rst   (ARESET),
    .push  (w_push_ok),
    .pop   (w_pop),
    .wdata ({AW_Master_ID, AW_Len, AW_Is_Split}),
    .rdata (w_head),
    .full  (Queue_Full),
    .empty (Queue_Empty),
    .count (Queue_Count)
  );

  assign {w_head_id, w_head_len, w_head_split} = w_head;

  assign w_valid     = !Queue_Empty;
  assign w_beat      = w_valid && W_Beat_Accept;
  assign w_last_beat = (r_beat_cnt == w_head_len);
  assign w_pop       = w_beat && w_last_beat;
  assign w_push_ok   = AW_Access_Grant && (!Queue_Full || w_pop);

  // Beat counter, head-seen tracker and overflow strobe.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_beat_cnt  <= '0;
      r_head_seen <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      if (w_pop)       r_beat_cnt <= '0;
      else if (w_beat) r_beat_cnt <= r_beat_cnt + 1'b1;
      r_head_seen <= w_valid && !w_pop;
      r_ovf       <= AW_Access_Grant && !w_push_ok;
    end
  end

`ifdef WDATA_ORDER_WLAST_CHECK_EN
  logic r_len_err;

  // Flag a beat whose WLAST disagrees with the beat count.
  always_ff @(posedge ACLK) begin
    if (ARESET) r_len_err <= 1'b0;
    else        r_len_err <= w_beat && (W_Last != w_last_beat);
  end

  assign Len_Error = r_len_err;
`else
  logic w_unused_last;
  assign w_unused_last = W_Last;
  assign Len_Error     = 1'b0;
`endif

  assign Master_Valid            = w_valid;
  assign Write_Data_Master       = w_valid ? w_head_id : '0;
  assign Is_Master_Part_Of_Split = w_valid && w_head_split;
  assign Beats_Remaining = w_valid ?
    ({1'b0, w_head_len} + 1'b1 - {1'b0, r_beat_cnt}) : '0;
  assign Write_Data_HandShake_En_Pulse = w_valid && !r_head_seen;
  assign Overflow_Err = r_ovf;

endmodule

// File: tb/tb_wdata_order_queue.sv
// Bench for wdata_order_queue: directed steps then random traffic
// against a queue-based reference model.
module tb_wdata_order_queue;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       grant;
  logic [1:0] mid;
  logic [7:0] alen;
  logic       asplit;
  logic       acc;
  logic       wlast;
  logic       full, empty, mvalid, wsplit, pulse, ovf, lerr;
  logic [2:0] cnt;
  logic [1:0] wmaster;
  logic [8:0] brem;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int id;
    int len;
    bit split;
  } ent_t;

  ent_t q[$];
  int   m_beats = 0;
  bit   m_seen  = 0;
  bit   m_ovf   = 0;
  bit   m_lerr  = 0;
  int   n_pulse = 0;

  always #5 clk = ~clk;

  wdata_order_queue dut (
    .ACLK                          (clk),
    .ARESET                        (rst),
    .AW_Access_Grant               (grant),
    .AW_Master_ID                  (mid),
    .AW_Len                        (alen),
    .AW_Is_Split                   (asplit),
    .W_Beat_Accept                 (acc),
    .W_Last                        (wlast),
    .Queue_Full                    (full),
    .Queue_Empty                   (empty),
    .Queue_Count                   (cnt),
    .Master_Valid                  (mvalid),
    .Write_Data_Master             (wmaster),
    .Is_Master_Part_Of_Split       (wsplit),
    .Beats_Remaining               (brem),
    .Write_Data_HandShake_En_Pulse (pulse),
    .Overflow_Err                  (ovf),
    .Len_Error                     (lerr)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    bit v;
    v = (q.size() > 0);
    chk("empty", int'(empty), int'(!v));
    chk("full", int'(full), int'(q.size() == DEPTH));
    chk("count", int'(cnt), q.size());
    chk("valid", int'(mvalid), int'(v));
    chk("master", int'(wmaster), v ? q[0].id : 0);
    chk("split", int'(wsplit), v ? int'(q[0].split) : 0);
    chk("remain", int'(brem), v ? q[0].len + 1 - m_beats : 0);
    chk("pulse", int'(pulse), int'(v && !m_seen));
    chk("ovf", int'(ovf), int'(m_ovf));
    chk("lenerr", int'(lerr), int'(m_lerr));
    if (v && !m_seen) n_pulse++;
  endtask

  // One clock: check outputs, drive inputs, then advance the model.
  task automatic cyc(input bit r, input bit g, input int id,
                     input int ln, input bit sp, input bit a,
                     input bit l);
    bit v, pop, push_ok, lastb;
    @(negedge clk);
    chk_all();
    rst = r; grant = g; mid = 2'(id); alen = 8'(ln);
    asplit = sp; acc = a; wlast = l;
    @(posedge clk);
    #1;
    if (r) begin
      q.delete();
      m_beats = 0; m_seen = 0; m_ovf = 0; m_lerr = 0;
      return;
    end
    v       = (q.size() > 0);
    lastb   = v && (m_beats == q[0].len);
    pop     = v && a && lastb;
    push_ok = g && (q.size() < DEPTH || pop);
    m_ovf   = g && !push_ok;
`ifdef WDATA_ORDER_WLAST_CHECK_EN
    m_lerr  = v && a && (l != lastb);
`else
    m_lerr  = 0;
`endif
    m_seen  = v && !pop;
    if (pop) begin
      void'(q.pop_front());
      m_beats = 0;
    end else if (v && a) begin
      m_beats++;
    end
    if (push_ok) q.push_back('{id: id, len: ln, split: sp});
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic beat(input bit l);
    cyc(0, 0, 0, 0, 0, 1, l);
  endtask

  initial begin
    rst = 1; grant = 0; mid = 0; alen = 0;
    asplit = 0; acc = 0; wlast = 0;
    @(posedge clk);
    cyc(1, 0, 0, 0, 0, 0, 0);

    // Single 4-beat burst from master 2.
    cyc(0, 1, 2, 3, 1, 0, 0);
    beat(0); beat(0); beat(0); beat(1);
    idle();

    // Fill with len=0 entries, then overflow.
    cyc(0, 1, 1, 0, 0, 0, 0);
    cyc(0, 1, 3, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 2, 0, 1, 0, 0);
    cyc(0, 1, 3, 0, 0, 0, 0);
    idle();

    // Final beat plus grant while full, then drain.
    cyc(0, 1, 1, 0, 1, 1, 1);
    n_pulse = 0;
    beat(1); beat(1); beat(1); beat(1);
    idle();
    chk("pulses", n_pulse, 4);

    // WLAST early on a 3-beat burst.
    cyc(0, 1, 0, 2, 0, 0, 0);
    beat(0); beat(1); beat(1);
    idle();

    // Reset mid-burst with two entries.
    cyc(0, 1, 1, 3, 0, 0, 0);
    cyc(0, 1, 2, 1, 0, 1, 0);
    beat(0);
    cyc(1, 1, 3, 2, 0, 1, 0);
    idle();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      bit r;
      r = ($urandom_range(0, 99) < 2);
      cyc(r, ($urandom_range(0, 99) < 40), $urandom_range(0, 3),
          ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255)
                                      : $urandom_range(0, 3),
          1'($urandom), ($urandom_range(0, 99) < 70),
          1'($urandom));
    end
    @(negedge clk);
    chk_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
